// File: rtl/opcode_pkg.sv
// Op-code constants and legality check shared by the issue queue and the
// downstream opcode decoder.
package opcode_pkg;

  localparam logic [3:0] OP_IDLE    = 4'b0000;
  localparam logic [3:0] OP_WRITE_A = 4'b0001;
  localparam logic [3:0] OP_WRITE_B = 4'b0010;
  localparam logic [3:0] OP_READ_C  = 4'b1011;

  function automatic bit is_legal_op(input logic [3:0] op);
    return (op == OP_WRITE_A) || (op == OP_WRITE_B) || (op == OP_READ_C);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous flush. Full and empty are derived from
// an occupancy counter so the pointers can simply wrap.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after a push writes it,
  // and leaving the array unreset lets it map onto plain RAM/flops without a
  // reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/opcode_issue_queue.sv
// Buffers host op codes, drops illegal ones, and issues at most one legal op
// per clock on a registered op_code/op_valid pair for the decoder.
module opcode_issue_queue
  import opcode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic                   flush,
  input  logic                   stall,
  output logic [3:0]             op_code,
  output logic                   op_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             illegal_cnt,
  output logic [CNT_W-1:0]       issued_cnt
);

  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] head_op;
  logic       accept;
  logic       in_legal;
  logic       fifo_push;
  logic       issue_fire;
  logic       illegal_hit;

  // A full queue refuses input even if the head is leaving this cycle.
  assign in_ready    = !fifo_full;
  assign in_legal    = is_legal_op(in_op);
  assign accept      = in_valid && in_ready && !flush;
  assign fifo_push   = accept && in_legal;
  assign illegal_hit = accept && !in_legal;
  assign issue_fire  = !stall && !fifo_empty && !flush;

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (issue_fire),
    .flush (flush),
    .wdata (in_op),
    .rdata (head_op),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Idle cycles present OP_IDLE so the decoder lands in its default arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code  <= OP_IDLE;
      op_valid <= 1'b0;
    end else if (issue_fire) begin
      op_code  <= head_op;
      op_valid <= 1'b1;
    end else begin
      op_code  <= OP_IDLE;
      op_valid <= 1'b0;
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
      issued_cnt  <= '0;
    end else begin
      if (illegal_hit && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
      if (issue_fire) issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_opcode_issue_queue.sv
// Directed bench for opcode_issue_queue: ordering, filtering, full/flush
// boundaries, counter saturation and asynchronous reset.
module tb_opcode_issue_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic             flush;
  logic             stall;
  logic [3:0]       op_code;
  logic             op_valid;
  logic [3:0]       level;
  logic [7:0]       illegal_cnt;
  logic [CNT_W-1:0] issued_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] seq [9] = '{4'h1, 4'h2, 4'hB, 4'h2, 4'h1, 4'hB, 4'hB, 4'h1, 4'h2};

  opcode_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .flush       (flush),
    .stall       (stall),
    .op_code     (op_code),
    .op_valid    (op_valid),
    .level       (level),
    .illegal_cnt (illegal_cnt),
    .issued_cnt  (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_op = 4'h0; flush = 1'b0; stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_code, level, in_ready} !== {1'b0, 4'h0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b code=%h level=%0d ready=%b, want 0 0 0 1",
               op_valid, op_code, level, in_ready);
    end
    checks++;
    if ({illegal_cnt, issued_cnt} !== {8'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_counters: got illegal=%0d issued=%0d, want 0 0", illegal_cnt, issued_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    in_valid = 1'b1; in_op = 4'h1;
    tick();
    checks++;
    if ({op_valid, level} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL first_push_latency: got valid=%b level=%0d, want 0 1", op_valid, level);
    end
    in_op = 4'h2;
    tick();
    checks++;
    if ({op_valid, op_code} !== {1'b1, 4'h1}) begin
      errors++;
      $display("FAIL issue_write_a: got valid=%b code=%h, want 1 1", op_valid, op_code);
    end
    in_op = 4'hB;
    tick();
    checks++;
    if ({op_valid, op_code} !== {1'b1, 4'h2}) begin
      errors++;
      $display("FAIL issue_write_b: got valid=%b code=%h, want 1 2", op_valid, op_code);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({op_valid, op_code} !== {1'b1, 4'hB}) begin
      errors++;
      $display("FAIL issue_read_c: got valid=%b code=%h, want 1 b", op_valid, op_code);
    end
    tick();
    checks++;
    if ({op_valid, op_code, level, issued_cnt} !== {1'b0, 4'h0, 4'd0, 16'd3}) begin
      errors++;
      $display("FAIL in_order_idle: got valid=%b code=%h level=%0d issued=%0d, want 0 0 0 3",
               op_valid, op_code, level, issued_cnt);
    end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_op = 4'h5;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ready: got ready=%b, want 1", in_ready);
    end
    tick();
    in_op = 4'hF;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({op_valid, level, illegal_cnt} !== {1'b0, 4'd0, 8'd2}) begin
      errors++;
      $display("FAIL illegal_filter: got valid=%b level=%0d illegal=%0d, want 0 0 2",
               op_valid, level, illegal_cnt);
    end
    tick();
    checks++;
    if ({op_valid, level} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL illegal_never_issues: got valid=%b level=%0d, want 0 0", op_valid, level);
    end
  endtask

  task automatic fill_stalled(input int n);
    stall = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_op = seq[i];
      tick();
    end
  endtask

  task automatic test_fill_and_drain();
    fill_stalled(DEPTH);
    checks++;
    if ({level, in_ready} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL full_state: got level=%0d ready=%b, want 8 0", level, in_ready);
    end
    in_op = seq[8];
    tick();
    tick();
    checks++;
    if ({level, op_valid} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL ninth_held_off: got level=%0d valid=%b, want 8 0", level, op_valid);
    end
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if ({op_valid, op_code} !== {1'b1, seq[i]}) begin
        errors++;
        $display("FAIL drain_order[%0d]: got valid=%b code=%h, want 1 %h", i, op_valid, op_code, seq[i]);
      end
      if (i == 0) begin
        checks++;
        if ({in_ready, level} !== {1'b1, 4'd7}) begin
          errors++;
          $display("FAIL ready_after_pop: got ready=%b level=%0d, want 1 7", in_ready, level);
        end
      end
    end
    tick();
    checks++;
    if ({op_valid, level, issued_cnt} !== {1'b0, 4'd0, 16'd11}) begin
      errors++;
      $display("FAIL drain_done: got valid=%b level=%0d issued=%0d, want 0 0 11", op_valid, level, issued_cnt);
    end
  endtask

  task automatic test_full_pop_no_push();
    fill_stalled(DEPTH);
    in_valid = 1'b1; in_op = 4'hB; stall = 1'b0;
    tick();
    checks++;
    if ({level, op_valid, op_code, in_ready} !== {4'd7, 1'b1, seq[0], 1'b1}) begin
      errors++;
      $display("FAIL full_pop_no_push: got level=%0d valid=%b code=%h ready=%b, want 7 1 %h 1",
               level, op_valid, op_code, in_ready, seq[0]);
    end
    stall = 1'b1;
    tick();
    checks++;
    if ({level, op_valid} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL push_after_full: got level=%0d valid=%b, want 8 0", level, op_valid);
    end
    in_valid = 1'b0; stall = 1'b0;
    repeat (DEPTH) tick();
    checks++;
    if ({op_valid, op_code, issued_cnt} !== {1'b1, 4'hB, 16'd20}) begin
      errors++;
      $display("FAIL late_push_issued: got valid=%b code=%h issued=%0d, want 1 b 20",
               op_valid, op_code, issued_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    fill_stalled(5);
    checks++;
    if (level !== 4'd5) begin
      errors++;
      $display("FAIL flush_setup: got level=%0d, want 5", level);
    end
    flush = 1'b1; stall = 1'b0; in_valid = 1'b1; in_op = 4'h1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({level, op_valid, op_code} !== {4'd0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL flush_clear: got level=%0d valid=%b code=%h, want 0 0 0", level, op_valid, op_code);
    end
    checks++;
    if ({issued_cnt, illegal_cnt} !== {16'd20, 8'd2}) begin
      errors++;
      $display("FAIL flush_counters: got issued=%0d illegal=%0d, want 20 2", issued_cnt, illegal_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({op_valid, level} !== {1'b0, 4'd0}) begin
        errors++;
        $display("FAIL flushed_push_gone[%0d]: got valid=%b level=%0d, want 0 0", i, op_valid, level);
      end
    end
  endtask

  task automatic test_saturate_and_async_reset();
    in_valid = 1'b1; in_op = 4'hF;
    repeat (300) tick();
    checks++;
    if (illegal_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL illegal_saturate: got illegal=%h, want ff", illegal_cnt);
    end
    in_op = 4'h1;
    repeat (3) tick();
    checks++;
    if ({op_valid, level, issued_cnt} !== {1'b1, 4'd1, 16'd22}) begin
      errors++;
      $display("FAIL pre_reset_busy: got valid=%b level=%0d issued=%0d, want 1 1 22", op_valid, level, issued_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_code, level, in_ready} !== {1'b0, 4'h0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset_outputs: got valid=%b code=%h level=%0d ready=%b, want 0 0 0 1",
               op_valid, op_code, level, in_ready);
    end
    checks++;
    if ({illegal_cnt, issued_cnt} !== {8'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_reset_counters: got illegal=%0d issued=%0d, want 0 0", illegal_cnt, issued_cnt);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({op_valid, level} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_idle: got valid=%b level=%0d, want 0 0", op_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_illegal();
    test_fill_and_drain();
    test_full_pop_no_push();
    test_flush();
    test_saturate_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
